// File: rtl/pwm_deadtime_gen.sv
// Half-bridge gate driver stage: turns a PWM stream into complementary high/low-side drives
// with programmable dead time, short-pulse suppression and a sticky fault latch.
module pwm_deadtime_gen #(
    parameter int unsigned DT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dt_cfg,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                hs_out,
    output logic                ls_out,
    output logic                busy,
    output logic                fault_latched
);

    localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDtHi,
        StHi,
        StDtLo,
        StLo
    } state_e;

    state_e              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] dt_eff;
    logic                pwm_q;
    logic                fault_d;

    // A zero dead time would let both switches overlap; clamp it to one cycle.
    assign dt_eff = (dt_cfg == '0) ? DT_ONE : dt_cfg;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_latched;
        if (fault) begin
            state_d = StIdle;
            cnt_d   = '0;
            fault_d = 1'b1;
        end else if (fault_latched) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (fault_clr) begin
                fault_d = 1'b0;
            end
        end else if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = pwm_q ? StDtHi : StDtLo;
                    cnt_d   = dt_eff;
                end
                StDtHi: begin
                    if (!pwm_q) begin
                        state_d = StDtLo;
                        cnt_d   = dt_eff;
                    end else if (cnt_q == DT_ONE) begin
                        state_d = StHi;
                    end else begin
                        cnt_d = cnt_q - DT_ONE;
                    end
                end
                StDtLo: begin
                    if (pwm_q) begin
                        state_d = StDtHi;
                        cnt_d   = dt_eff;
                    end else if (cnt_q == DT_ONE) begin
                        state_d = StLo;
                    end else begin
                        cnt_d = cnt_q - DT_ONE;
                    end
                end
                StHi: begin
                    if (!pwm_q) begin
                        state_d = StDtLo;
                        cnt_d   = dt_eff;
                    end
                end
                StLo: begin
                    if (pwm_q) begin
                        state_d = StDtHi;
                        cnt_d   = dt_eff;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pwm_q         <= 1'b0;
            fault_latched <= 1'b0;
            hs_out        <= 1'b0;
            ls_out        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_in;
            fault_latched <= fault_d;
            hs_out        <= (state_d == StHi);
            ls_out        <= (state_d == StLo);
            busy          <= (state_d == StDtHi) || (state_d == StDtLo);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: directed vectors push hand-computed outputs,
// a negedge monitor pops and compares; a random phase checks output exclusivity.
module tb_pwm_deadtime_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pwm_in;
    logic [3:0] dt_cfg;
    logic       fault;
    logic       fault_clr;
    logic       hs_out;
    logic       ls_out;
    logic       busy;
    logic       fault_latched;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned vec_idx  = 0;

    // Expected {hs, ls, busy, fault_latched} after each stimulus edge.
    logic [3:0] exp_q[$];

    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_HI   = 4'b1000;
    localparam logic [3:0] O_LO   = 4'b0100;
    localparam logic [3:0] O_DT   = 4'b0010;
    localparam logic [3:0] O_FLT  = 4'b0001;

    pwm_deadtime_gen #(
        .DT_WIDTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_in       (pwm_in),
        .dt_cfg       (dt_cfg),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .busy         (busy),
        .fault_latched(fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            vec_idx = vec_idx + 1;
            n_checks = n_checks + 1;
            if ({hs_out, ls_out, busy, fault_latched} !== e) begin
                n_errors = n_errors + 1;
                $display("FAIL vec%0d hs/ls/busy/flt: got %b required %b", vec_idx,
                         {hs_out, ls_out, busy, fault_latched}, e);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Apply inputs before an edge, queue the outputs expected after it, return at the negedge.
    task automatic step(input logic e, input logic p, input logic [3:0] d, input logic f,
                        input logic c, input logic [3:0] ex);
        en        = e;
        pwm_in    = p;
        dt_cfg    = d;
        fault     = f;
        fault_clr = c;
        @(posedge clk);
        exp_q.push_back(ex);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic p, input logic [3:0] d, input logic [3:0] ex);
        for (int i = 0; i < n; i++) step(1'b1, p, d, 1'b0, 1'b0, ex);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        pwm_in    = 1'b0;
        dt_cfg    = 4'd3;
        fault     = 1'b0;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {hs_out, ls_out, busy, fault_latched}, O_IDLE);
        rst_n = 1'b1;

        // Start-up into LO with D=3
        run(3, 1'b0, 4'd3, O_DT);
        run(2, 1'b0, 4'd3, O_LO);
        // LO -> HI transition
        run(1, 1'b1, 4'd3, O_LO);
        run(3, 1'b1, 4'd3, O_DT);
        run(2, 1'b1, 4'd3, O_HI);
        // HI -> LO
        run(1, 1'b0, 4'd3, O_HI);
        run(3, 1'b0, 4'd3, O_DT);
        run(2, 1'b0, 4'd3, O_LO);
        // Two-cycle pulse is swallowed, DT_HI restarts as DT_LO
        run(1, 1'b1, 4'd3, O_LO);
        run(1, 1'b1, 4'd3, O_DT);
        run(4, 1'b0, 4'd3, O_DT);
        run(2, 1'b0, 4'd3, O_LO);
        // DT_CFG=0 behaves as one dead cycle
        run(1, 1'b1, 4'd0, O_LO);
        run(1, 1'b1, 4'd0, O_DT);
        run(6, 1'b1, 4'd0, O_HI);
        run(1, 1'b0, 4'd0, O_HI);
        run(1, 1'b0, 4'd0, O_DT);
        run(6, 1'b0, 4'd0, O_LO);
        run(1, 1'b1, 4'd0, O_LO);
        run(1, 1'b1, 4'd0, O_DT);
        run(2, 1'b1, 4'd0, O_HI);
        // Fault in HI, clear blocked while fault is held, then clear and restart
        step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, O_FLT);
        step(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, O_FLT);
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, O_IDLE);
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, O_DT);
        run(2, 1'b1, 4'd0, O_HI);
        // EN drop mid dead time, then DT_CFG change during dead time is ignored
        run(1, 1'b0, 4'd3, O_HI);
        run(1, 1'b0, 4'd3, O_DT);
        step(1'b0, 1'b0, 4'd3, 1'b0, 1'b0, O_IDLE);
        run(1, 1'b0, 4'd3, O_DT);
        run(2, 1'b0, 4'd1, O_DT);
        run(1, 1'b0, 4'd1, O_LO);
        // Into HI for the asynchronous reset test
        run(1, 1'b1, 4'd1, O_LO);
        run(1, 1'b1, 4'd1, O_DT);
        run(2, 1'b1, 4'd1, O_HI);

        #2;
        check("scoreboard_drained_pre_reset", 4'(exp_q.size()), 4'd0);
        check("hi_before_reset", {hs_out, ls_out, busy, fault_latched}, O_HI);
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_hi", {hs_out, ls_out, busy, fault_latched}, O_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Random PWM/DT/EN with occasional faults: outputs must stay mutually exclusive
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            pwm_in    = ($urandom_range(0, 3) != 0) ? pwm_in : ~pwm_in;
            dt_cfg    = 4'($urandom_range(0, 15));
            fault     = ($urandom_range(0, 63) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            @(negedge clk);
            n_checks = n_checks + 1;
            if (!$onehot0({hs_out, ls_out, busy}) ||
                (fault_latched && (hs_out || ls_out || busy))) begin
                n_errors = n_errors + 1;
                $display("FAIL rand_excl cycle%0d: got hs/ls/busy/flt=%b required one-hot0",
                         i, {hs_out, ls_out, busy, fault_latched});
            end
        end

        #1;
        check("scoreboard_drained_end", 4'(exp_q.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
